rom32_arbiter: RTL
==================

// Module: rom32_arbiter
//
// PURPOSE
// - Shares one single-port, registered-address 32-bit ROM (1-cycle read latency) between two
//   read-only requesters: instruction fetch (ibus) and data load (dbus).
// - Decodes 32-bit byte addresses, flags out-of-range and misaligned accesses, and arbitrates round-robin.
// - Sits between the core's fetch/load units and the boot ROM macro; it owns the ROM address port.
//
// PARAMETERS
// - DEPTH      512           ROM depth in 32-bit words; ADDR_WIDTH = $clog2(DEPTH) (localparam).
// - BASE_ADDR  32'h0000_0000 Byte address of ROM word 0; must be 4-byte aligned.
//
// PORTS
// - i_clk        in   1           Single clock; all state updates on its rising edge.
// - i_rst_n      in   1           Reset: synchronous, active-low.
// - i_ibus_req   in   1           Fetch request; held with i_ibus_addr stable until o_ibus_ack.
// - i_ibus_addr  in   32          Fetch byte address.
// - o_ibus_ack   out  1           One-cycle completion pulse for the fetch request.
// - o_ibus_err   out  1           Error flag, valid only while o_ibus_ack is high.
// - o_ibus_data  out  32          Read data, valid only while o_ibus_ack is high; 0 otherwise.
// - i_dbus_req   in   1           Load request; same rules as ibus.
// - i_dbus_addr  in   32          Load byte address.
// - o_dbus_ack   out  1           One-cycle completion pulse for the load request.
// - o_dbus_err   out  1           Error flag, valid only while o_dbus_ack is high.
// - o_dbus_data  out  32          Read data, valid only while o_dbus_ack is high; 0 otherwise.
// - o_rom_addr   out  ADDR_WIDTH  Word index driven to the ROM; the ROM registers it on i_clk.
// - i_rom_data   in   32          ROM data, valid the cycle after o_rom_addr is sampled.
//
// BEHAVIOUR
// - Decode
//   - off = addr - BASE_ADDR (32-bit wrap).
//   - Error if addr[1:0] != 0 or off[31:2] >= DEPTH; otherwise word index = off[ADDR_WIDTH+1:2].
// - Pipeline registers
//   - r_busy: access in flight.
//   - r_owner: 0 = ibus, 1 = dbus.
//   - r_err: decode error captured for the in-flight access.
//   - r_last: owner of the last grant.
// - Arbitration (combinational, every cycle)
//   - Eligible requester: req high AND it is not the requester being acked this cycle.
//   - One eligible requester: it is granted.
//   - Both eligible: grant goes to !r_last (round-robin).
//   - Grant at edge N: r_busy=1, r_owner=grantee, r_err=decode error, r_last=grantee.
//     o_rom_addr = grantee's word index in cycle N; held at its last value when nothing is granted.
//   - No grant: r_busy=0.
// - Completion (cycle N+1, while r_busy=1)
//   - o_<owner>_ack=1.
//   - o_<owner>_data = r_err ? 0 : i_rom_data.
//   - o_<owner>_err = r_err.
//   - Fixed latency: req sampled with a grant in cycle N -> ack in cycle N+1.
// - Back-to-back
//   - In an ack cycle the other requester may be granted, giving 1 access/cycle when both are busy.
//   - The acked requester may keep req high after ack to present its next address.
//     It is eligible from the following cycle, so same-requester rate is 1 access / 2 cycles.
// - Error accesses
//   - Take the same slot and latency as good ones; the ROM address is don't-care.
// - Protocol assumption
//   - Dropping req or changing addr before ack is a protocol violation; behaviour is undefined.
// - Reset (i_rst_n=0 at an edge)
//   - r_busy=0, r_owner=0, r_err=0, r_last=1 (ibus wins the first tie), o_rom_addr=0.
//   - All acks/errs 0 and all data 0 from the next cycle.
//   - An in-flight access is dropped silently: no ack is issued for it.
//
// TESTING
// - Single fetch: after reset, ibus_req with addr 0x0000_0010, ROM word 4 = 0xDEADBEEF.
//   -> o_rom_addr=4 in the same cycle; o_ibus_ack=1 with data 0xDEADBEEF next cycle; err=0.
// - Simultaneous: ibus addr 0x0, dbus addr 0x8 both asserted and held.
//   -> ibus acked in cycle 1, dbus in cycle 2, ibus re-granted in cycle 2 and acked in cycle 3.
//   -> Acks alternate every cycle with correct words.
// - Errors: dbus addr 0x0000_0802 (misaligned), then 0x0000_0800 with DEPTH=512 (out of range).
//   -> Each gets ack=1, err=1, data=0 one cycle after grant.
// - BASE_ADDR=0x1000_0000: ibus addr 0x1000_07FC -> o_rom_addr=511, valid.
//   -> ibus addr 0x0FFF_FFFC -> err=1.
// - Reset mid-op: assert i_rst_n=0 in the cycle after a dbus grant.
//   -> No dbus ack ever appears; after release, the first tie is granted to ibus.
// - Streaming: ibus req held high alone for 8 cycles with the address advancing after each ack.
//   -> Exactly 4 acks, one every other cycle, each with the data for its own address.

Source files
------------

// File: rtl/rom32_arbiter.sv
// Round-robin arbiter sharing one registered-address 32-bit boot ROM between
// an instruction-fetch port and a data-load port, with address range and alignment checks.
module rom32_arbiter #(
   parameter int unsigned DEPTH     = 512,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_ibus_req,
   input  logic [31:0]                i_ibus_addr,
   output logic                       o_ibus_ack,
   output logic                       o_ibus_err,
   output logic [31:0]                o_ibus_data,
   input  logic                       i_dbus_req,
   input  logic [31:0]                i_dbus_addr,
   output logic                       o_dbus_ack,
   output logic                       o_dbus_err,
   output logic [31:0]                o_dbus_data,
   output logic [$clog2(DEPTH)-1:0]   o_rom_addr,
   input  logic [31:0]                i_rom_data
);

   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [29:0] DEPTH_W    = 30'(DEPTH);
   localparam logic [29:0] BASE_W     = BASE_ADDR[31:2];

   typedef enum logic {
      OWN_IBUS = 1'b0,
      OWN_DBUS = 1'b1
   } owner_e;

   logic                  busy_q;
   owner_e                owner_q;
   logic                  err_q;
   owner_e                last_q;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;

   logic [29:0]           iword, dword;
   logic                  idec_err, ddec_err;
   logic                  acking_i, acking_d;
   logic                  elig_i, elig_d;
   logic                  gnt_valid;
   owner_e                gnt_owner;
   logic                  gnt_err;
   logic [ADDR_WIDTH-1:0] gnt_idx;

   // BASE_ADDR is word aligned, so the word offset is exact on the upper address bits
   assign iword    = i_ibus_addr[31:2] - BASE_W;
   assign dword    = i_dbus_addr[31:2] - BASE_W;
   assign idec_err = (i_ibus_addr[1:0] != 2'b00) || (iword >= DEPTH_W);
   assign ddec_err = (i_dbus_addr[1:0] != 2'b00) || (dword >= DEPTH_W);

   always_comb begin
      acking_i  = busy_q && (owner_q == OWN_IBUS);
      acking_d  = busy_q && (owner_q == OWN_DBUS);
      elig_i    = i_ibus_req && !acking_i;
      elig_d    = i_dbus_req && !acking_d;
      gnt_valid = elig_i || elig_d;
      gnt_owner = OWN_IBUS;
      if (elig_i && elig_d) begin
         gnt_owner = (last_q == OWN_IBUS) ? OWN_DBUS : OWN_IBUS;
      end else if (elig_d) begin
         gnt_owner = OWN_DBUS;
      end
      gnt_err    = (gnt_owner == OWN_DBUS) ? ddec_err : idec_err;
      gnt_idx    = (gnt_owner == OWN_DBUS) ? dword[ADDR_WIDTH-1:0] : iword[ADDR_WIDTH-1:0];
      rom_addr_d = gnt_valid ? gnt_idx : rom_addr_q;
   end

   assign o_rom_addr = rom_addr_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         busy_q     <= 1'b0;
         owner_q    <= OWN_IBUS;
         err_q      <= 1'b0;
         last_q     <= OWN_DBUS;
         rom_addr_q <= '0;
      end else begin
         busy_q     <= gnt_valid;
         rom_addr_q <= rom_addr_d;
         if (gnt_valid) begin
            owner_q <= gnt_owner;
            err_q   <= gnt_err;
            last_q  <= gnt_owner;
         end
      end
   end

   // Acks are masked while reset is held so an access caught by reset never completes
   assign o_ibus_ack  = busy_q && (owner_q == OWN_IBUS) && i_rst_n;
   assign o_dbus_ack  = busy_q && (owner_q == OWN_DBUS) && i_rst_n;
   assign o_ibus_err  = o_ibus_ack && err_q;
   assign o_dbus_err  = o_dbus_ack && err_q;
   assign o_ibus_data = (o_ibus_ack && !err_q) ? i_rom_data : '0;
   assign o_dbus_data = (o_dbus_ack && !err_q) ? i_rom_data : '0;

endmodule
